vga_pixel_colorizer: RTL and testbench
======================================

Name: vga_pixel_colorizer

Overview:
- Parametrised successor to the single-mode pixel colour stage: converts the 1-bit pixel stream and display-area flag into registered R/G/B.
- Adds selectable foreground colour, PWM brightness dimming, frame-synchronous blink and a colour-bar test pattern.
- Configuration is double-buffered and applied only at frame start, so no mid-frame tearing.
- Sits between the character/pixel serialiser and the VGA DAC pins in the vga_clk domain.

Parameters:
CW, 3, bits per colour channel (R, G and B each CW wide)
PWM_W, 3, brightness/PWM counter width
BLINK_FRAMES, 32, frame_start pulses per blink half-period (>=2)
BAR_SHIFT, 4, log2 of colour-bar width in pixels (test pattern)

Ports:
vga_clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
display_area  in  1  high during visible pixels
pixel_on  in  1  serialised foreground pixel bit
frame_start  in  1  one-cycle pulse at start of vertical blanking
cfg_load  in  1  one-cycle pulse; capture cfg_* into shadow registers
cfg_color  in  2  0 white, 1 red, 2 green, 3 blue
cfg_mode  in  2  0 normal, 1 pwm-dim, 2 blink, 3 test pattern
cfg_bright  in  PWM_W  brightness level for mode 1
cfg_pending  out  1  shadow loaded, not yet active
R  out  CW  red
G  out  CW  green
B  out  CW  blue

Behaviour:
- Reset is asynchronous and active-high; clock is vga_clk. On reset: R=G=B=0, cfg_pending=0; shadow and active config = colour white, mode normal, bright all-ones; pwm_cnt=0, frame_cnt=0, blink_phase=0, col_cnt=0.
- Config handshake:
  - cfg_load=1: shadow <= cfg_*, cfg_pending <= 1.
  - frame_start=1 with cfg_pending=1: active <= shadow, cfg_pending <= 0.
  - cfg_load and frame_start in the same cycle: active <= cfg_* inputs directly, shadow <= cfg_*, cfg_pending <= 0.
  - A second cfg_load before frame_start overwrites the shadow (last write wins).
- Active config is visible to the output logic the cycle after the update.
- pwm_cnt: free-running PWM_W-bit counter incrementing every vga_clk; wraps from all-ones to 0.
- pwm_on = (active bright == all-ones) OR (pwm_cnt < active bright). bright=0 means always off; all-ones means always on.
- Blink:
  - frame_cnt counts frame_start pulses 0..BLINK_FRAMES-1.
  - On the pulse where frame_cnt==BLINK_FRAMES-1: frame_cnt <= 0, blink_phase toggles.
  - Counts run in every mode and are not cleared by config changes.
- col_cnt: cleared to 0 whenever display_area=0; increments each cycle display_area=1; saturates at all-ones. Width = BAR_SHIFT+3.
- Foreground colour vector: white = all channels all-ones; red/green/blue = that channel all-ones, others 0.
- Output, registered with 1-cycle latency from display_area/pixel_on:
  - display_area=0: RGB=0 in every mode.
  - mode 0: pixel_on ? colour : 0.
  - mode 1: (pixel_on & pwm_on) ? colour : 0.
  - mode 2: (pixel_on & ~blink_phase) ? colour : 0.
  - mode 3: pixel_on ignored. bar = col_cnt[BAR_SHIFT+2:BAR_SHIFT]; R={CW{bar[2]}}, G={CW{bar[1]}}, B={CW{bar[0]}}.
- Reset mid-frame forces RGB=0 immediately (async) and discards any pending config.

Decomposition:
- Shared package vga_pkg:
  - colour codes COL_WHITE/RED/GREEN/BLUE (2-bit)
  - mode codes MODE_NORMAL/PWM/BLINK/TEST (2-bit)
  - typedef cfg_t {color, mode, bright}
- One natural sub-module: vga_cfg_shadow, containing the shadow/active registers and pending handshake, reused by other VGA config consumers.
- Counters and output mux stay in the top.

Test Plan:
- Reset then display_area=1, pixel_on=1, no config -> RGB=7/7/7 one cycle later; display_area=0 -> 0/0/0 one cycle later.
- cfg_load color=1 mode=0 mid-frame -> cfg_pending=1, output stays white; after frame_start -> pending=0, lit pixels give R=7 G=0 B=0.
- mode=1, bright=3, pixel_on held high 16 cycles -> output red on exactly 3 of each 8 cycles (pwm_cnt 0..2). bright=0 -> never lit; bright=7 -> always lit.
- mode=2: lit for frame_start pulses 1..32, dark for 33..64, lit again from pulse 65.
- mode=3, display_area high 128 cycles -> bars of 16 pixels: 0/0/0, 0/0/7, 0/7/0, 0/7/7, 7/0/0, 7/0/7, 7/7/0, 7/7/7; col_cnt restarts at the next line.
- cfg_load and frame_start in the same cycle with color=3 -> blue active next cycle, pending=0. Assert reset while pending=1 -> pending=0, RGB=0, white restored.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour/mode codes, configuration record and the
// foreground colour lookup used by the pixel colour stages.
package vga_pkg;

  // Widest brightness field any consumer may use; narrower users zero-extend.
  localparam int unsigned BRIGHT_MAX_W = 8;

  typedef enum logic [1:0] {
    COL_WHITE = 2'd0,
    COL_RED   = 2'd1,
    COL_GREEN = 2'd2,
    COL_BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_PWM    = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_TEST   = 2'd3
  } mode_e;

  typedef struct packed {
    color_e                  color;
    mode_e                   mode;
    logic [BRIGHT_MAX_W-1:0] bright;
  } cfg_t;

  // Channel enables as {r, g, b}.
  function automatic logic [2:0] color_mask(input color_e c);
    logic [2:0] m;
    case (c)
      COL_WHITE: m = 3'b111;
      COL_RED:   m = 3'b100;
      COL_GREEN: m = 3'b010;
      COL_BLUE:  m = 3'b001;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_cfg_shadow.sv
// Double-buffered configuration: cfg_load fills a shadow copy, which becomes
// active on the next frame_start so changes never land mid-frame.
module vga_cfg_shadow
  import vga_pkg::*;
#(
  parameter cfg_t RESET_CFG = '{color: COL_WHITE, mode: MODE_NORMAL, bright: '1}
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic cfg_load,
  input  logic frame_start,
  input  cfg_t cfg_in,
  output cfg_t active_cfg,
  output logic cfg_pending
);

  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;
  logic pending_q, pending_d;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (cfg_load) begin
      shadow_d = cfg_in;
    end
    // A load coinciding with frame start bypasses the shadow entirely.
    if (cfg_load && frame_start) begin
      active_d  = cfg_in;
      pending_d = 1'b0;
    end else if (cfg_load) begin
      pending_d = 1'b1;
    end else if (frame_start && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= RESET_CFG;
      active_q  <= RESET_CFG;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_cfg  = active_q;
  assign cfg_pending = pending_q;

endmodule

// File: rtl/vga_pixel_colorizer.sv
// Pixel colour stage: maps the serialised pixel bit and display-area flag to
// registered R/G/B with selectable colour, PWM dimming, blink and colour bars.
module vga_pixel_colorizer
  import vga_pkg::*;
#(
  parameter int unsigned CW           = 3,
  parameter int unsigned PWM_W        = 3,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned BAR_SHIFT    = 4
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             display_area,
  input  logic             pixel_on,
  input  logic             frame_start,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_color,
  input  logic [1:0]       cfg_mode,
  input  logic [PWM_W-1:0] cfg_bright,
  output logic             cfg_pending,
  output logic [CW-1:0]    R,
  output logic [CW-1:0]    G,
  output logic [CW-1:0]    B
);

  localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned COL_W = BAR_SHIFT + 3;
  // Full brightness for this instance's PWM width, in the shared field width.
  localparam logic [BRIGHT_MAX_W-1:0] BRIGHT_FULL = BRIGHT_MAX_W'((1 << PWM_W) - 1);
  localparam cfg_t RESET_CFG = '{color: COL_WHITE, mode: MODE_NORMAL, bright: BRIGHT_FULL};

  cfg_t cfg_in;
  cfg_t active;

  assign cfg_in = '{
    color:  color_e'(cfg_color),
    mode:   mode_e'(cfg_mode),
    bright: BRIGHT_MAX_W'(cfg_bright)
  };

  vga_cfg_shadow #(
    .RESET_CFG(RESET_CFG)
  ) u_cfg_shadow (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .frame_start (frame_start),
    .cfg_in      (cfg_in),
    .active_cfg  (active),
    .cfg_pending (cfg_pending)
  );

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;

  logic       pwm_on;
  logic [2:0] bar;
  logic [2:0] fg_mask;
  logic [2:0] lit_mask;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // Column counter restarts every line and sticks at its maximum.
    col_cnt_d = col_cnt_q;
    if (!display_area) begin
      col_cnt_d = '0;
    end else if (col_cnt_q != '1) begin
      col_cnt_d = col_cnt_q + COL_W'(1);
    end
  end

  always_comb begin
    pwm_on  = (active.bright == BRIGHT_FULL) ||
              (BRIGHT_MAX_W'(pwm_cnt_q) < active.bright);
    bar     = col_cnt_q[BAR_SHIFT+2:BAR_SHIFT];
    fg_mask = color_mask(active.color);

    lit_mask = '0;
    if (display_area) begin
      case (active.mode)
        MODE_NORMAL: if (pixel_on)                   lit_mask = fg_mask;
        MODE_PWM:    if (pixel_on && pwm_on)         lit_mask = fg_mask;
        MODE_BLINK:  if (pixel_on && !blink_phase_q) lit_mask = fg_mask;
        MODE_TEST:   lit_mask = bar;
        default:     lit_mask = '0;
      endcase
    end

    r_d = {CW{lit_mask[2]}};
    g_d = {CW{lit_mask[1]}};
    b_d = {CW{lit_mask[0]}};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      col_cnt_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      col_cnt_q     <= col_cnt_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign R = r_q;
  assign G = g_q;
  assign B = b_q;

endmodule

// File: tb/tb_vga_pixel_colorizer.sv
// Directed self-checking bench for vga_pixel_colorizer.
module tb_vga_pixel_colorizer;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       display_area;
  logic       pixel_on;
  logic       frame_start;
  logic       cfg_load;
  logic [1:0] cfg_color;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_bright;
  logic       cfg_pending;
  logic [2:0] R, G, B;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned nf       = 0;

  always #5 vga_clk = ~vga_clk;

  vga_pixel_colorizer #(
    .CW(3),
    .PWM_W(3),
    .BLINK_FRAMES(32),
    .BAR_SHIFT(4)
  ) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .display_area (display_area),
    .pixel_on     (pixel_on),
    .frame_start  (frame_start),
    .cfg_load     (cfg_load),
    .cfg_color    (cfg_color),
    .cfg_mode     (cfg_mode),
    .cfg_bright   (cfg_bright),
    .cfg_pending  (cfg_pending),
    .R            (R),
    .G            (G),
    .B            (B)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_rgb(input string tag, input int unsigned r, input int unsigned g,
                           input int unsigned b);
    check({tag, ".R"}, R, r);
    check({tag, ".G"}, G, g);
    check({tag, ".B"}, B, b);
  endtask

  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    nf++;
  endtask

  task automatic load_cfg(input logic [1:0] c, input logic [1:0] m, input logic [2:0] b);
    cfg_color  = c;
    cfg_mode   = m;
    cfg_bright = b;
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
  endtask

  initial begin
    int unsigned lit;
    int unsigned bar;
    logic [2:0] brights [3] = '{3'd3, 3'd0, 3'd7};
    int unsigned pwm_exp [3] = '{6, 0, 16};

    reset = 1'b1; display_area = 1'b0; pixel_on = 1'b0; frame_start = 1'b0;
    cfg_load = 1'b0; cfg_color = 2'd0; cfg_mode = 2'd0; cfg_bright = 3'd0;
    repeat (2) @(negedge vga_clk);
    check_rgb("reset", 0, 0, 0);
    check("reset_pending", cfg_pending, 0);
    reset = 1'b0;
    nf = 0;

    // Default config is white, normal mode.
    display_area = 1'b1; pixel_on = 1'b1;
    step();
    check_rgb("default_white", 7, 7, 7);
    display_area = 1'b0;
    step();
    check_rgb("blanked", 0, 0, 0);

    // Shadowed load only takes effect at frame start.
    display_area = 1'b1;
    load_cfg(2'd1, 2'd0, 3'd7);
    check("pending_set", cfg_pending, 1);
    check_rgb("shadow_not_active", 7, 7, 7);
    pulse_frame();
    check("pending_clear", cfg_pending, 0);
    check_rgb("switch_edge_old", 7, 7, 7);
    step();
    check_rgb("red_active", 7, 0, 0);
    pixel_on = 1'b0;
    step();
    check_rgb("red_pixel_off", 0, 0, 0);
    pixel_on = 1'b1;

    load_cfg(2'd2, 2'd0, 3'd7);
    load_cfg(2'd3, 2'd0, 3'd7);
    pulse_frame();
    step();
    check_rgb("last_write_wins", 0, 0, 7);

    // PWM: 16 consecutive cycles span two full periods of the 3-bit counter.
    for (int i = 0; i < 3; i++) begin
      load_cfg(2'd1, 2'd1, brights[i]);
      pulse_frame();
      lit = 0;
      repeat (16) begin
        step();
        if (R == 3'd7 && G == 3'd0 && B == 3'd0) lit++;
      end
      check($sformatf("pwm_bright%0d_lit", brights[i]), lit, pwm_exp[i]);
    end

    // Blink, from a fresh reset so frame counting starts at zero.
    reset = 1'b1;
    step();
    reset = 1'b0;
    nf = 0;
    cfg_color = 2'd1; cfg_mode = 2'd2; cfg_bright = 3'd7;
    cfg_load = 1'b1; frame_start = 1'b1;
    step();
    cfg_load = 1'b0; frame_start = 1'b0;
    nf = 1;
    check("blink_direct_pending", cfg_pending, 0);
    display_area = 1'b1; pixel_on = 1'b1;
    step();
    check_rgb("blink_after_1", 7, 0, 0);
    for (int n = 2; n <= 65; n++) begin
      pulse_frame();
      step();
      case (n)
        31: check_rgb("blink_after_31", 7, 0, 0);
        32: check_rgb("blink_after_32", 0, 0, 0);
        33: check_rgb("blink_after_33", 0, 0, 0);
        63: check_rgb("blink_after_63", 0, 0, 0);
        64: check_rgb("blink_after_64", 7, 0, 0);
        65: check_rgb("blink_after_65", 7, 0, 0);
        default: ;
      endcase
    end

    // Colour bars, 16 pixels wide, column counter saturating at 127.
    load_cfg(2'd0, 2'd3, 3'd7);
    pulse_frame();
    display_area = 1'b0; pixel_on = 1'b0;
    step();
    check_rgb("bars_blank", 0, 0, 0);
    display_area = 1'b1;
    for (int i = 0; i < 140; i++) begin
      step();
      if ((i % 16 == 0) || (i % 16 == 15) || (i == 130) || (i == 139)) begin
        bar = (i >= 128) ? 7 : i / 16;
        check_rgb($sformatf("bar_px%0d", i), ((bar >> 2) & 1) * 7,
                  ((bar >> 1) & 1) * 7, (bar & 1) * 7);
      end
    end
    display_area = 1'b0;
    step();
    check_rgb("bars_hblank", 0, 0, 0);
    display_area = 1'b1;
    repeat (17) step();
    check_rgb("bars_restart_px16", 0, 0, 7);

    // Load coinciding with frame start goes straight to active.
    cfg_color = 2'd3; cfg_mode = 2'd0; cfg_bright = 3'd7;
    cfg_load = 1'b1; frame_start = 1'b1;
    step();
    cfg_load = 1'b0; frame_start = 1'b0;
    nf++;
    check("direct_pending", cfg_pending, 0);
    pixel_on = 1'b1;
    step();
    check_rgb("direct_blue", 0, 0, 7);

    // Asynchronous reset discards a pending load.
    load_cfg(2'd1, 2'd0, 3'd7);
    check("pre_reset_pending", cfg_pending, 1);
    check_rgb("pre_reset_blue", 0, 0, 7);
    #2 reset = 1'b1;
    #1;
    check_rgb("async_reset", 0, 0, 0);
    check("async_reset_pending", cfg_pending, 0);
    @(negedge vga_clk);
    reset = 1'b0;
    step();
    check_rgb("post_reset_white", 7, 7, 7);
    pulse_frame();
    step();
    check_rgb("pending_discarded", 7, 7, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
